hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Next-generation hazard unit for the 5-stage pipelined MIPS core.
- Keeps the E-stage and D-stage forwarding and the load-use and branch stalls, generalised to a parametrised register-address width.
- Adds a registered scoreboard for a multi-cycle multiply/divide unit (MDU) in E, plus D-stage flush on taken branch or jump.
- Adds saturating stall and flush performance counters.
- Sits beside the datapath; drives the F/D/E pipeline-register enables and clears, and the forwarding muxes.

Parameters:
- RA_W, 5, register-address width in bits; register 0 is hard-wired zero.
- MDU_LAT, 4, MDU latency in cycles, from start in E until HI/LO are valid; legal range 2..15.
- CNT_W, 16, width of each performance counter.

Ports:
- HU_CLK  in  1  core clock, rising edge.
- HU_RST  in  1  reset, asynchronous, active-high.
- HU_BranchD  in  1  branch instruction in D.
- HU_PCSrcD  in  1  branch taken, resolved in D.
- HU_JumpD  in  1  jump instruction in D.
- HU_MduUseD  in  1  instruction in D is an MDU op or reads HI/LO.
- HU_RsD, HU_RtD, HU_RsE, HU_RtE  in  RA_W  source register addresses.
- HU_WriteRegE, HU_WriteRegM, HU_WriteRegW  in  RA_W  destination register addresses.
- HU_MemtoRegE, HU_RegWriteE, HU_RegWriteM, HU_RegWriteW  in  1  pipeline control bits.
- HU_MduStartE  in  1  MDU op present in E; MDU starts this cycle.
- HU_CntClr  in  1  synchronous clear of both counters.
- HU_StallF, HU_StallD, HU_FlushD, HU_FlushE  out  1  pipeline control.
- HU_ForwardAD, HU_ForwardBD  out  1  D-stage forward from M.
- HU_ForwardAE, HU_ForwardBE  out  2  E-stage forward select: 10 = M, 01 = W, 00 = register file.
- HU_MduBusy  out  1  MDU result pending.
- HU_MduDone  out  1  one-cycle pulse in the last busy cycle.
- HU_StallCnt, HU_FlushCnt  out  CNT_W  performance counters.

Behaviour:
- Reset (asynchronous, HU_RST=1):
  - MDU countdown = 0, so HU_MduBusy = 0 and HU_MduDone = 0.
  - HU_StallCnt = 0, HU_FlushCnt = 0.
  - Combinational outputs follow their inputs with the scoreboard cleared.
  - Reset asserted mid-MDU-operation aborts it immediately.
- ForwardAE:
  - 10 if RsE != 0, RsE == WriteRegM and RegWriteM.
  - Else 01 if RsE != 0, RsE == WriteRegW and RegWriteW.
  - Else 00.
  - M has priority over W.
  - ForwardBE is identical using RtE.
- ForwardAD = RsD != 0, RsD == WriteRegM and RegWriteM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE, RtE != 0, and (RsD == RtE or RtD == RtE).
- branchstall = BranchD and either:
  - RegWriteE, with a nonzero RsD or RtD equal to WriteRegE; or
  - MemtoRegM-equivalent M hit: RegWriteM, with a nonzero RsD or RtD equal to WriteRegM and the M instruction being a load.
  - Loads are not identifiable from M on this port list, so use RegWriteM with any M hit (conservative).
- MDU scoreboard (4-bit down-counter cnt, registered):
  - HU_MduStartE and not HU_FlushE: cnt <= MDU_LAT - 1.
  - Else if cnt != 0: cnt <= cnt - 1.
  - HU_MduBusy = (cnt != 0).
  - HU_MduDone = (cnt == 1).
  - A start while busy reloads cnt; the previous op is superseded.
- mdustall = HU_MduUseD and HU_MduBusy. A dependent instruction issues in the cycle after HU_MduDone.
- stall = lwstall | branchstall | mdustall.
  - HU_StallF = HU_StallD = HU_FlushE = stall.
- HU_FlushD = (HU_PCSrcD | HU_JumpD) and not stall. Stall takes priority; the branch re-resolves after the stall.
- Counters, at each rising edge:
  - HU_CntClr: counter <= 0. Clear wins over increment.
  - Else HU_StallCnt += 1 when HU_StallD.
  - Else HU_FlushCnt += 1 when HU_FlushD.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset mid-op: start MDU, assert HU_RST after 1 cycle -> cnt = 0, Busy = 0, counters = 0 immediately, without waiting for a clock edge.
- Forwarding priority: RsE = 3, WriteRegM = WriteRegW = 3, both RegWrite = 1 -> ForwardAE = 10. With RsE = 0 -> ForwardAE = 00.
- Load-use stall: MemtoRegE = 1, RtE = 5, RsD = 5 -> StallF/StallD/FlushE = 1 for one cycle; StallCnt = 1.
- MDU, MDU_LAT = 4: start at cycle 0 -> Busy in cycles 1..3, Done in cycle 3. MduUseD held -> StallD in cycles 1..3 and clear at cycle 4.
- Taken branch with no hazard -> FlushD = 1, FlushCnt + 1. Same branch with branchstall -> FlushD = 0 while stalled, then 1 after the stall.
- Counter saturation at CNT_W = 4: hold a stall for 20 cycles -> StallCnt = 15. Then assert CntClr together with a stall -> StallCnt = 0.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS core: forwarding, load-use/branch/MDU stalls,
// D-stage flush on taken control flow, and saturating stall/flush counters.
`timescale 1ns/1ps
module hazard_unit_mc #(
    parameter int unsigned RA_W    = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              HU_CLK,
    input  logic              HU_RST,
    input  logic              HU_BranchD,
    input  logic              HU_PCSrcD,
    input  logic              HU_JumpD,
    input  logic              HU_MduUseD,
    input  logic [RA_W-1:0]   HU_RsD,
    input  logic [RA_W-1:0]   HU_RtD,
    input  logic [RA_W-1:0]   HU_RsE,
    input  logic [RA_W-1:0]   HU_RtE,
    input  logic [RA_W-1:0]   HU_WriteRegE,
    input  logic [RA_W-1:0]   HU_WriteRegM,
    input  logic [RA_W-1:0]   HU_WriteRegW,
    input  logic              HU_MemtoRegE,
    input  logic              HU_RegWriteE,
    input  logic              HU_RegWriteM,
    input  logic              HU_RegWriteW,
    input  logic              HU_MduStartE,
    input  logic              HU_CntClr,
    output logic              HU_StallF,
    output logic              HU_StallD,
    output logic              HU_FlushD,
    output logic              HU_FlushE,
    output logic              HU_ForwardAD,
    output logic              HU_ForwardBD,
    output logic [1:0]        HU_ForwardAE,
    output logic [1:0]        HU_ForwardBE,
    output logic              HU_MduBusy,
    output logic              HU_MduDone,
    output logic [CNT_W-1:0]  HU_StallCnt,
    output logic [CNT_W-1:0]  HU_FlushCnt
);

    localparam int unsigned MDU_CW = 4;

    logic [MDU_CW-1:0] mdu_cnt;
    logic              rs_d_nz;
    logic              rt_d_nz;
    logic              lw_stall;
    logic              branch_stall;
    logic              mdu_stall;
    logic              stall;
    logic              flush_d;

    assign rs_d_nz = (HU_RsD != '0);
    assign rt_d_nz = (HU_RtD != '0);

    // E-stage forwarding: M result is newer than W, so it wins.
    always_comb begin
        HU_ForwardAE = 2'b00;
        HU_ForwardBE = 2'b00;
        if (HU_RsE != '0 && HU_RsE == HU_WriteRegM && HU_RegWriteM)
            HU_ForwardAE = 2'b10;
        else if (HU_RsE != '0 && HU_RsE == HU_WriteRegW && HU_RegWriteW)
            HU_ForwardAE = 2'b01;
        if (HU_RtE != '0 && HU_RtE == HU_WriteRegM && HU_RegWriteM)
            HU_ForwardBE = 2'b10;
        else if (HU_RtE != '0 && HU_RtE == HU_WriteRegW && HU_RegWriteW)
            HU_ForwardBE = 2'b01;
    end

    assign HU_ForwardAD = rs_d_nz && (HU_RsD == HU_WriteRegM) && HU_RegWriteM;
    assign HU_ForwardBD = rt_d_nz && (HU_RtD == HU_WriteRegM) && HU_RegWriteM;

    assign lw_stall = HU_MemtoRegE && (HU_RtE != '0) &&
                      ((HU_RsD == HU_RtE) || (HU_RtD == HU_RtE));

    // Any M-stage writer hit counts, since loads cannot be told apart in M.
    assign branch_stall = HU_BranchD && (
        (HU_RegWriteE && ((rs_d_nz && HU_RsD == HU_WriteRegE) ||
                          (rt_d_nz && HU_RtD == HU_WriteRegE))) ||
        (HU_RegWriteM && ((rs_d_nz && HU_RsD == HU_WriteRegM) ||
                          (rt_d_nz && HU_RtD == HU_WriteRegM))));

    assign HU_MduBusy = (mdu_cnt != '0);
    assign HU_MduDone = (mdu_cnt == MDU_CW'(1));
    assign mdu_stall  = HU_MduUseD && HU_MduBusy;

    assign stall   = lw_stall || branch_stall || mdu_stall;
    assign flush_d = (HU_PCSrcD || HU_JumpD) && !stall;

    assign HU_StallF = stall;
    assign HU_StallD = stall;
    assign HU_FlushE = stall;
    assign HU_FlushD = flush_d;

    // MDU scoreboard; a flushed start never launches and a new start supersedes the old op.
    always_ff @(posedge HU_CLK or posedge HU_RST) begin
        if (HU_RST)
            mdu_cnt <= '0;
        else if (HU_MduStartE && !stall)
            mdu_cnt <= MDU_CW'(MDU_LAT - 1);
        else if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - MDU_CW'(1);
    end

    // Saturating performance counters; clear takes precedence over counting.
    always_ff @(posedge HU_CLK or posedge HU_RST) begin
        if (HU_RST) begin
            HU_StallCnt <= '0;
            HU_FlushCnt <= '0;
        end else if (HU_CntClr) begin
            HU_StallCnt <= '0;
            HU_FlushCnt <= '0;
        end else if (stall) begin
            if (HU_StallCnt != '1)
                HU_StallCnt <= HU_StallCnt + CNT_W'(1);
        end else if (flush_d) begin
            if (HU_FlushCnt != '1)
                HU_FlushCnt <= HU_FlushCnt + CNT_W'(1);
        end
    end

endmodule
